// File: rtl/riscv_v_pkg.sv
// Shared types for the vector writeback stage: the element-size encoding and the buffered entry.
// Entry data fields are sized for the widest supported configuration; narrower instances zero-pad.
package riscv_v_pkg;

  localparam int VLEN_MAX = 1024;
  localparam int XLEN_MAX = 64;

  typedef enum logic [1:0] {
    OSIZE_8  = 2'd0,
    OSIZE_16 = 2'd1,
    OSIZE_32 = 2'd2,
    OSIZE_64 = 2'd3
  } osize_e;

  typedef struct packed {
    logic [VLEN_MAX-1:0] data;
    logic [XLEN_MAX-1:0] idata;
    logic [4:0]          dst;
    logic                vrf_wr;
    logic                irf_wr;
  } riscv_v_wb_entry_t;

endpackage

// File: rtl/riscv_v_wb_stage_if.sv
// EXE->WB handshake plus vector/integer register-file write ports.
// master = the writeback stage, slave = the surrounding pipeline and register files.
interface riscv_v_wb_stage_if #(
  parameter int DATA_W = 128,
  parameter int INT_W  = 32
) ();
  import riscv_v_pkg::*;

  logic                valid_exe;
  logic                ready_exe;
  logic [DATA_W-1:0]   vec_result_exe;
  logic [INT_W-1:0]    int_result_exe;
  logic [DATA_W/8-1:0] mask_result_exe;
  logic [DATA_W-1:0]   old_vd_exe;
  logic [DATA_W/8-1:0] mask_exe;
  osize_e              osize_exe;
  logic [4:0]          dst_exe;
  logic                is_masked_exe;
  logic                is_vec_wr_exe;
  logic                is_int_wr_exe;
  logic                is_mask_wr_exe;
  logic                rf_stall;
  logic                vrf_we;
  logic [4:0]          vrf_waddr;
  logic [DATA_W-1:0]   vrf_wdata;
  logic                irf_we;
  logic [4:0]          irf_waddr;
  logic [INT_W-1:0]    irf_wdata;
  logic [31:0]         vpending;

  modport master (
    input  valid_exe, vec_result_exe, int_result_exe, mask_result_exe, old_vd_exe,
           mask_exe, osize_exe, dst_exe, is_masked_exe, is_vec_wr_exe, is_int_wr_exe,
           is_mask_wr_exe, rf_stall,
    output ready_exe, vrf_we, vrf_waddr, vrf_wdata, irf_we, irf_waddr, irf_wdata, vpending
  );

  modport slave (
    output valid_exe, vec_result_exe, int_result_exe, mask_result_exe, old_vd_exe,
           mask_exe, osize_exe, dst_exe, is_masked_exe, is_vec_wr_exe, is_int_wr_exe,
           is_mask_wr_exe, rf_stall,
    input  ready_exe, vrf_we, vrf_waddr, vrf_wdata, irf_we, irf_waddr, irf_wdata, vpending
  );

endinterface

// File: rtl/riscv_v_wb_merge.sv
// Combinational merge of an EXE result with the old destination value (element masking or mask-write).
// Zero latency, no flow control.
module riscv_v_wb_merge
  import riscv_v_pkg::*;
#(
  parameter  int DATA_W = 128,
  localparam int NB     = DATA_W / 8
) (
  input  logic [DATA_W-1:0] vec_result_i,
  input  logic [DATA_W-1:0] old_vd_i,
  input  logic [NB-1:0]     mask_result_i,
  input  logic [NB-1:0]     mask_i,
  input  osize_e            osize_i,
  input  logic              is_masked_i,
  input  logic              is_mask_wr_i,
  output logic [DATA_W-1:0] wdata_o
);

  localparam int IDX_W = $clog2(NB);

  logic [DATA_W-1:0] vec_merged;
  logic [DATA_W-1:0] mask_merged;
  logic [IDX_W-1:0]  elem;

  // Byte b belongs to element b >> osize, so that element's mask bit gates the whole byte.
  always_comb begin
    vec_merged  = old_vd_i;
    mask_merged = old_vd_i;
    elem        = '0;
    for (int b = 0; b < NB; b++) begin
      elem = IDX_W'(b >> osize_i);
      if (!is_masked_i || mask_i[elem]) begin
        vec_merged[8*b +: 8] = vec_result_i[8*b +: 8];
      end
    end
    mask_merged[NB-1:0] = mask_result_i;
    wdata_o = is_mask_wr_i ? mask_merged : vec_merged;
  end

endmodule

// File: rtl/riscv_v_wb_stage.sv
// Vector writeback stage: merges results into a DEPTH-entry FIFO, drains the head to the RF ports.
// One cycle min latency; ready_exe = not full (registered), rf_stall holds the head without blocking pushes.
module riscv_v_wb_stage
  import riscv_v_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int INT_W  = 32,
  parameter int DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  riscv_v_wb_stage_if.master wb
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  riscv_v_wb_entry_t mem_q [DEPTH];

  riscv_v_wb_entry_t new_entry;
  riscv_v_wb_entry_t head;
  logic [DATA_W-1:0] merged;
  logic [31:0]       vpend;
  logic              push;
  logic              pop;
  logic              unused_head;

  riscv_v_wb_merge #(.DATA_W(DATA_W)) u_merge (
    .vec_result_i  (wb.vec_result_exe),
    .old_vd_i      (wb.old_vd_exe),
    .mask_result_i (wb.mask_result_exe),
    .mask_i        (wb.mask_exe),
    .osize_i       (wb.osize_exe),
    .is_masked_i   (wb.is_masked_exe),
    .is_mask_wr_i  (wb.is_mask_wr_exe),
    .wdata_o       (merged)
  );

  // Gated by rst so the stage never advertises space while held in reset.
  assign wb.ready_exe = rst && (count_q < CNT_W'(DEPTH));
  assign push         = wb.valid_exe && wb.ready_exe;
  assign pop          = (count_q != '0) && !wb.rf_stall;
  assign head         = mem_q[rptr_q];

  always_comb begin
    new_entry        = '0;
    new_entry.data   = VLEN_MAX'(merged);
    new_entry.idata  = XLEN_MAX'(wb.int_result_exe);
    new_entry.dst    = wb.dst_exe;
    new_entry.vrf_wr = wb.is_vec_wr_exe || wb.is_mask_wr_exe;
    new_entry.irf_wr = wb.is_int_wr_exe;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    end
    if (push) begin
      valid_d[wptr_q] = 1'b1;
      wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= new_entry;
    end
  end

  // Derived from live entries only, so a same-cycle pop/push of one register keeps its bit.
  always_comb begin
    vpend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && mem_q[i].vrf_wr) begin
        vpend[mem_q[i].dst] = 1'b1;
      end
    end
  end

  assign wb.vpending  = vpend;
  assign wb.vrf_we    = pop && head.vrf_wr;
  assign wb.vrf_waddr = head.dst;
  assign wb.vrf_wdata = head.data[DATA_W-1:0];
  assign wb.irf_we    = pop && head.irf_wr && (head.dst != 5'd0);
  assign wb.irf_waddr = head.dst;
  assign wb.irf_wdata = head.idata[INT_W-1:0];

  assign unused_head  = ^{head.data, head.idata};

endmodule

// File: tb/tb_riscv_v_wb_stage.sv
// Directed bench for riscv_v_wb_stage at DATA_W=128, INT_W=32, DEPTH=2.
module tb_riscv_v_wb_stage;
  import riscv_v_pkg::*;

  localparam logic [127:0] ALL_AA = {16{8'hAA}};
  localparam logic [127:0] ALL_55 = {16{8'h55}};
  localparam logic [127:0] X1 = 128'h10000000_20000000_30000000_40000001;
  localparam logic [127:0] X2 = 128'h50000000_60000000_70000000_80000002;
  localparam logic [127:0] X3 = 128'h90000000_A0000000_B0000000_C0000003;

  logic clk;
  logic rst;
  int   passes = 0;
  int   fails  = 0;
  int   total  = 0;

  riscv_v_wb_stage_if #(.DATA_W(128), .INT_W(32)) wb ();

  riscv_v_wb_stage #(.DATA_W(128), .INT_W(32), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    wb.valid_exe      = 1'b0;
    wb.is_vec_wr_exe  = 1'b0;
    wb.is_int_wr_exe  = 1'b0;
    wb.is_mask_wr_exe = 1'b0;
    wb.is_masked_exe  = 1'b0;
  endtask

  task automatic push_vec(input logic [4:0] dst, input logic [1:0] osz, input logic [127:0] res,
                          input logic [127:0] old, input logic [15:0] mask, input logic masked);
    drive_idle();
    wb.valid_exe      = 1'b1;
    wb.is_vec_wr_exe  = 1'b1;
    wb.is_masked_exe  = masked;
    wb.dst_exe        = dst;
    wb.osize_exe      = osize_e'(osz);
    wb.vec_result_exe = res;
    wb.old_vd_exe     = old;
    wb.mask_exe       = mask;
  endtask

  task automatic push_int(input logic [4:0] dst, input logic [31:0] val);
    drive_idle();
    wb.valid_exe      = 1'b1;
    wb.is_int_wr_exe  = 1'b1;
    wb.dst_exe        = dst;
    wb.int_result_exe = val;
  endtask

  initial begin
    rst = 1'b0;
    drive_idle();
    wb.rf_stall        = 1'b0;
    wb.vec_result_exe  = '0;
    wb.int_result_exe  = '0;
    wb.mask_result_exe = '0;
    wb.old_vd_exe      = '0;
    wb.mask_exe        = '0;
    wb.osize_exe       = OSIZE_8;
    wb.dst_exe         = '0;

    // Reset state
    #12;
    chk("rst_ready", wb.ready_exe, 0);
    chk("rst_vrf_we", wb.vrf_we, 0);
    chk("rst_irf_we", wb.irf_we, 0);
    chk("rst_vpending", wb.vpending, 0);
    tick();
    rst = 1'b1;
    settle();
    chk("post_rst_ready", wb.ready_exe, 1);

    // Unmasked 32-bit vector write to v3
    push_vec(5'd3, 2'd2, 128'h0F0E0D0C, ALL_AA, 16'h0000, 1'b0);
    settle();
    chk("t1_empty_vrf_we", wb.vrf_we, 0);
    tick();
    drive_idle();
    settle();
    chk("t1_vrf_we", wb.vrf_we, 1);
    chk("t1_waddr", wb.vrf_waddr, 3);
    chk("t1_wdata", wb.vrf_wdata, 128'h0F0E0D0C);
    chk("t1_vpending", wb.vpending, 32'h8);
    tick();
    settle();
    chk("t1_drained_we", wb.vrf_we, 0);
    chk("t1_drained_vpend", wb.vpending, 0);

    // Masked merge, 8-bit elements
    push_vec(5'd4, 2'd0, ALL_55, ALL_AA, 16'h00FF, 1'b1);
    tick();
    drive_idle();
    settle();
    chk("t2_e8_wdata", wb.vrf_wdata, {ALL_AA[63:0], ALL_55[63:0]});
    chk("t2_e8_waddr", wb.vrf_waddr, 4);
    tick();

    // Masked merge, 16-bit elements 0 and 2 enabled
    push_vec(5'd4, 2'd1, ALL_55, ALL_AA, 16'h0005, 1'b1);
    tick();
    drive_idle();
    settle();
    chk("t2_e16_wdata", wb.vrf_wdata, 128'hAAAAAAAAAAAAAAAAAAAA_5555_AAAA_5555);
    tick();

    // 64-bit elements: only mask bits 0..1 matter
    push_vec(5'd4, 2'd3, ALL_55, ALL_AA, 16'hFFF2, 1'b1);
    tick();
    drive_idle();
    settle();
    chk("t2_e64_wdata", wb.vrf_wdata, {ALL_55[63:0], ALL_AA[63:0]});
    tick();

    // Mask write: low 16 bits from mask ALU, rest undisturbed
    drive_idle();
    wb.valid_exe       = 1'b1;
    wb.is_mask_wr_exe  = 1'b1;
    wb.dst_exe         = 5'd9;
    wb.mask_result_exe = 16'h1234;
    wb.old_vd_exe      = ALL_AA;
    tick();
    drive_idle();
    settle();
    chk("t2_mask_we", wb.vrf_we, 1);
    chk("t2_mask_waddr", wb.vrf_waddr, 9);
    chk("t2_mask_wdata", wb.vrf_wdata, {ALL_AA[127:16], 16'h1234});
    tick();

    // Stall fill, then drain with a same-cycle push/pop to the same register
    wb.rf_stall = 1'b1;
    push_vec(5'd10, 2'd2, X1, ALL_AA, 16'h0000, 1'b0);
    settle();
    chk("t3_ready_0", wb.ready_exe, 1);
    tick();
    push_vec(5'd11, 2'd2, X2, ALL_AA, 16'h0000, 1'b0);
    settle();
    chk("t3_ready_1", wb.ready_exe, 1);
    chk("t3_stalled_we", wb.vrf_we, 0);
    tick();
    push_vec(5'd12, 2'd2, X3, ALL_AA, 16'h0000, 1'b0);
    settle();
    chk("t3_full_ready", wb.ready_exe, 0);
    chk("t3_full_vpend", wb.vpending, 32'h0C00);
    tick();
    drive_idle();
    wb.rf_stall = 1'b0;
    settle();
    chk("t3_w1_we", wb.vrf_we, 1);
    chk("t3_w1_addr", wb.vrf_waddr, 10);
    chk("t3_w1_data", wb.vrf_wdata, X1);
    tick();
    push_vec(5'd11, 2'd2, X3, ALL_AA, 16'h0000, 1'b0);
    settle();
    chk("t3_w2_ready", wb.ready_exe, 1);
    chk("t3_w2_addr", wb.vrf_waddr, 11);
    chk("t3_w2_data", wb.vrf_wdata, X2);
    chk("t3_w2_vpend", wb.vpending, 32'h0800);
    tick();
    drive_idle();
    settle();
    chk("t3_w3_we", wb.vrf_we, 1);
    chk("t3_w3_data", wb.vrf_wdata, X3);
    chk("t3_w3_vpend", wb.vpending, 32'h0800);
    tick();
    settle();
    chk("t3_done_we", wb.vrf_we, 0);
    chk("t3_done_vpend", wb.vpending, 0);

    // Integer writes: x0 dropped, x7 written
    push_int(5'd0, 32'hDEADBEEF);
    tick();
    push_int(5'd7, 32'h12345678);
    settle();
    chk("t4_x0_irf_we", wb.irf_we, 0);
    chk("t4_x0_vrf_we", wb.vrf_we, 0);
    chk("t4_x0_vpend", wb.vpending, 0);
    tick();
    drive_idle();
    settle();
    chk("t4_x7_irf_we", wb.irf_we, 1);
    chk("t4_x7_waddr", wb.irf_waddr, 7);
    chk("t4_x7_wdata", wb.irf_wdata, 32'h12345678);
    tick();
    settle();
    chk("t4_done_irf_we", wb.irf_we, 0);

    // Entry with no write flags
    drive_idle();
    wb.valid_exe = 1'b1;
    wb.dst_exe   = 5'd6;
    tick();
    drive_idle();
    settle();
    chk("t5_noflag_vrf_we", wb.vrf_we, 0);
    chk("t5_noflag_irf_we", wb.irf_we, 0);
    chk("t5_noflag_vpend", wb.vpending, 0);
    tick();

    // Reset with two entries buffered
    wb.rf_stall = 1'b1;
    push_vec(5'd1, 2'd2, X1, ALL_AA, 16'h0000, 1'b0);
    tick();
    push_vec(5'd2, 2'd2, X2, ALL_AA, 16'h0000, 1'b0);
    tick();
    drive_idle();
    settle();
    chk("t6_pre_vpend", wb.vpending, 32'h6);
    rst = 1'b0;
    settle();
    chk("t6_rst_vpend", wb.vpending, 0);
    chk("t6_rst_ready", wb.ready_exe, 0);
    wb.rf_stall = 1'b0;
    settle();
    chk("t6_rst_vrf_we", wb.vrf_we, 0);
    tick();
    #2;
    rst = 1'b1;
    settle();
    chk("t6_rel_ready", wb.ready_exe, 1);
    chk("t6_rel_vrf_we", wb.vrf_we, 0);
    tick();
    settle();
    chk("t6_stale_vrf_we", wb.vrf_we, 0);
    chk("t6_stale_vpend", wb.vpending, 0);

    // Pending tracking of v5
    wb.rf_stall = 1'b1;
    push_vec(5'd5, 2'd2, X3, ALL_AA, 16'h0000, 1'b0);
    tick();
    drive_idle();
    settle();
    chk("t7_vpend_set", wb.vpending, 32'h20);
    chk("t7_stalled_we", wb.vrf_we, 0);
    wb.rf_stall = 1'b0;
    settle();
    chk("t7_pop_we", wb.vrf_we, 1);
    chk("t7_pop_addr", wb.vrf_waddr, 5);
    tick();
    settle();
    chk("t7_vpend_clr", wb.vpending, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
